// File: rtl/c6_pkg.sv
// c6_pkg: shared cell, direction and FSM state types for the Connect6 board engine
package c6_pkg;
    typedef enum logic [1:0] {EMPTY = 2'b00, P0 = 2'b01, P1 = 2'b10} cell_t;
    typedef enum logic [1:0] {DIR_E, DIR_N, DIR_NE, DIR_SE} dir_t;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/c6_line_check.sv
// c6_line_check: flags a run of WIN_LEN identical non-empty cells that lies fully on the board
module c6_line_check
    import c6_pkg::*;
#(
    parameter int WIN_LEN = 6
) (
    input  logic [WIN_LEN-1:0][1:0] cells,
    input  logic                    inb,
    output logic                    hit,
    output cell_t                   owner
);
    // The run is a hit only when every cell matches the first, non-empty one
    always_comb begin
        owner = cell_t'(cells[0]);
        hit = inb && owner != EMPTY;
        for (int k = 1; k < WIN_LEN; k++) hit = hit && cells[k] == cells[0];
    end
endmodule

// File: rtl/connect6_board_engine.sv
// connect6_board_engine: board storage with checked placement and a one-pair-per-cycle win scanner
module connect6_board_engine
    import c6_pkg::*;
#(
    parameter int BOARD_N = 19,
    parameter int WIN_LEN = 6,
    parameter int CW = $clog2(BOARD_N),
    localparam int SCW = $clog2(BOARD_N * BOARD_N + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           place_valid,
    output logic           place_ready,
    input  logic [CW-1:0]  place_x,
    input  logic [CW-1:0]  place_y,
    input  logic           place_player,
    output logic           place_err,
    input  logic           scan_start,
    output logic           scan_busy,
    output logic           scan_done,
    output logic           win_found,
    output logic           win_player,
    output logic [CW-1:0]  win_x,
    output logic [CW-1:0]  win_y,
    output logic [1:0]     win_dir,
    output logic [SCW-1:0] stone_count
);
    cell_t board [BOARD_N][BOARD_N];
    state_t state, next;
    logic [CW-1:0] sx, sy;
    dir_t sd;
    logic [WIN_LEN-1:0][1:0] cells;
    logic inb, hit, last, fire, bad;
    cell_t owner;
    int dx, dy;

    assign fire = place_valid && place_ready;
    assign bad = (int'(place_x) >= BOARD_N || int'(place_y) >= BOARD_N) ? 1'b1 : board[place_x][place_y] != EMPTY;
    assign last = sx == CW'(BOARD_N - 1) && sy == CW'(BOARD_N - 1) && sd == DIR_SE;

    // Gather the WIN_LEN cells of the current (cell, direction) pair; off-board runs read as empty
    always_comb begin
        dx = (sd == DIR_N) ? 0 : 1;
        dy = (sd == DIR_E) ? 0 : (sd == DIR_SE) ? -1 : 1;
        inb = int'(sx) + (WIN_LEN - 1) * dx < BOARD_N && int'(sy) + (WIN_LEN - 1) * dy >= 0
              && int'(sy) + (WIN_LEN - 1) * dy < BOARD_N;
        cells = '0;
        if (inb) for (int k = 0; k < WIN_LEN; k++) cells[k] = board[sx + CW'(k * dx)][sy + CW'(k * dy)];
    end

    c6_line_check #(.WIN_LEN(WIN_LEN)) u_line (
        .cells(cells),
        .inb  (inb),
        .hit  (hit),
        .owner(owner)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= next;
    end

    // FSM next state: clear wins, scan ends on first hit or after the final pair
    always_comb begin
        next = clear ? IDLE : state == IDLE ? (scan_start ? SCAN : IDLE) :
               state == SCAN ? ((hit || last) ? DONE : SCAN) : IDLE;
    end

    // FSM outputs; placement is held off during reset, clear and a scan request
    always_comb begin
        scan_busy = state == SCAN;
        scan_done = state == DONE;
        place_ready = rst_n && state == IDLE && !clear && !scan_start;
    end

    // Board contents, scan position, latched result and stone count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int x = 0; x < BOARD_N; x++) for (int y = 0; y < BOARD_N; y++) board[x][y] <= EMPTY;
            {sx, sy, sd, place_err, stone_count} <= '0;
            {win_found, win_player, win_x, win_y, win_dir} <= '0;
        end else if (clear) begin
            for (int x = 0; x < BOARD_N; x++) for (int y = 0; y < BOARD_N; y++) board[x][y] <= EMPTY;
            {sx, sy, sd, place_err, stone_count} <= '0;
            {win_found, win_player, win_x, win_y, win_dir} <= '0;
        end else begin
            place_err <= fire && bad;
            if (fire && !bad) begin
                board[place_x][place_y] <= place_player ? P1 : P0;
                stone_count <= stone_count + SCW'(1);
            end
            if (state == IDLE && scan_start) begin
                {sx, sy, sd} <= '0;
                {win_found, win_player, win_x, win_y, win_dir} <= '0;
            end else if (state == SCAN) begin
                if (hit) {win_found, win_player, win_x, win_y, win_dir} <= {1'b1, owner == P1, sx, sy, sd};
                sd <= dir_t'(sd + 2'd1);
                if (sd == DIR_SE) begin
                    sy <= (sy == CW'(BOARD_N - 1)) ? '0 : sy + CW'(1);
                    if (sy == CW'(BOARD_N - 1)) sx <= sx + CW'(1);
                end
            end
        end
    end
endmodule
